// File: rtl/pipe3_cpu.sv
// pipe3_cpu: 3-stage 32-bit integer pipeline (IF/ID latch, operand read, execute) with a 32x32 register file.
// Optional FORWARD_EN macro bypasses the EX-stage ALU result into operand read.
module pipe3_cpu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ibus,
  output logic [31:0] abus,
  output logic [31:0] bbus,
  output logic [31:0] dbus
);
  typedef enum logic [2:0] {ALU_NOP, ALU_ADD, ALU_SUB, ALU_XOR, ALU_AND, ALU_OR} alu_e;
  logic [31:0] r_ir;
  logic [31:0] r_rf [32];
  alu_e        r_ex_op;
  logic [4:0]  r_ex_dest, r_wb_dest;
  logic        r_ex_we, r_wb_we;
  logic        w_is_r, w_we;
  logic [4:0]  w_rs, w_rt, w_dest;
  logic [31:0] w_imm, w_ra, w_rb, w_fa, w_fb, w_alu;
  alu_e        w_op;
  assign w_is_r = r_ir[31:26] == 6'd0;
  assign w_rs   = r_ir[25:21];
  assign w_rt   = r_ir[20:16];
  assign w_dest = w_is_r ? r_ir[15:11] : w_rt;
  assign w_imm  = {{16{r_ir[15]}}, r_ir[15:0]};
  assign w_ra   = w_rs == 5'd0 ? 32'd0 : r_rf[w_rs];
  assign w_rb   = w_rt == 5'd0 ? 32'd0 : r_rf[w_rt];
  assign w_we   = w_op != ALU_NOP && w_dest != 5'd0;
  always_comb begin
    w_op = ALU_NOP;
    if (w_is_r)
      case (r_ir[5:0])
        6'b000011: w_op = ALU_ADD;
        6'b000010: w_op = ALU_SUB;
        6'b000001: w_op = ALU_XOR;
        6'b000111: w_op = ALU_AND;
        6'b000100: w_op = ALU_OR;
        default:   w_op = ALU_NOP;
      endcase
    else
      case (r_ir[31:26])
        6'b000011: w_op = ALU_ADD;
        6'b000010: w_op = ALU_SUB;
        6'b000001: w_op = ALU_XOR;
        6'b001111: w_op = ALU_AND;
        6'b001100: w_op = ALU_OR;
        default:   w_op = ALU_NOP;
      endcase
  end
`ifdef FORWARD_EN
  // r_ex_we already implies a legal op with a nonzero destination
  assign w_fa = r_ex_we && r_ex_dest == w_rs ? w_alu : w_ra;
  assign w_fb = r_ex_we && r_ex_dest == w_rt ? w_alu : w_rb;
`else
  assign w_fa = w_ra;
  assign w_fb = w_rb;
`endif
  always_comb begin
    w_alu = 32'd0;
    case (r_ex_op)
      ALU_ADD: w_alu = abus + bbus;
      ALU_SUB: w_alu = abus - bbus;
      ALU_XOR: w_alu = abus ^ bbus;
      ALU_AND: w_alu = abus & bbus;
      ALU_OR:  w_alu = abus | bbus;
      default: w_alu = 32'd0;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ir      <= '0;
      abus      <= '0;
      bbus      <= '0;
      dbus      <= '0;
      r_ex_op   <= ALU_NOP;
      r_ex_dest <= '0;
      r_ex_we   <= 1'b0;
      r_wb_dest <= '0;
      r_wb_we   <= 1'b0;
    end else begin
      r_ir      <= ibus;
      abus      <= w_fa;
      bbus      <= w_is_r ? w_fb : w_imm;
      r_ex_op   <= w_op;
      r_ex_dest <= w_dest;
      r_ex_we   <= w_we;
      dbus      <= w_alu;
      r_wb_dest <= r_ex_dest;
      r_wb_we   <= r_ex_we;
    end
  end
  // Write-back on the falling edge so an instruction two slots later reads the new value
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n)
      for (int i = 0; i < 32; i++) r_rf[i] <= '0;
    else if (r_wb_we && r_wb_dest != 5'd0)
      r_rf[r_wb_dest] <= dbus;
  end
endmodule

// File: tb/tb_pipe3_cpu.sv
// tb_pipe3_cpu: scoreboard bench for pipe3_cpu; a reference model predicts operands and results per instruction.
module tb_pipe3_cpu;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ibus = '0;
  logic [31:0] abus, bbus, dbus;
  int n_chk = 0, n_err = 0;
  typedef struct {logic [31:0] a, b, d; int age;} exp_t;
  exp_t q[$];
  logic [31:0] m_rf [32];
  logic        p_we;
  logic [4:0]  p_dst;
  logic [31:0] p_val;
  pipe3_cpu dut (.clk(clk), .rst_n(rst_n), .ibus(ibus), .abus(abus), .bbus(bbus), .dbus(dbus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] rt_(input int f, input int rs, input int rt, input int rd);
    logic [5:0] ff = 6'(f);
    logic [4:0] s = 5'(rs), t = 5'(rt), d = 5'(rd);
    return {6'd0, s, t, d, 5'd0, ff};
  endfunction
  function automatic logic [31:0] it_(input int op, input int rs, input int rt, input logic [15:0] imm);
    logic [5:0] o = 6'(op);
    logic [4:0] s = 5'(rs), t = 5'(rt);
    return {o, s, t, imm};
  endfunction
  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    p_we = 1'b0; p_dst = '0; p_val = '0;
    q.delete();
  endtask
  task automatic issue(input logic [31:0] ins);
    logic [31:0] ra, rb, a, b, d;
    logic        isr, ok, we;
    logic [4:0]  rs, rt, dst;
    exp_t e;
    isr = ins[31:26] == 6'd0;
    rs = ins[25:21]; rt = ins[20:16];
    dst = isr ? ins[15:11] : rt;
    ra = m_rf[rs]; rb = m_rf[rt];
`ifdef FORWARD_EN
    if (p_we && p_dst == rs) ra = p_val;
    if (p_we && p_dst == rt) rb = p_val;
`endif
    a = ra;
    b = isr ? rb : {{16{ins[15]}}, ins[15:0]};
    ok = 1'b1; d = '0;
    case ({isr, isr ? ins[5:0] : ins[31:26]})
      7'h43, 7'h03: d = a + b;
      7'h42, 7'h02: d = a - b;
      7'h41, 7'h01: d = a ^ b;
      7'h47, 7'h0F: d = a & b;
      7'h44, 7'h0C: d = a | b;
      default: ok = 1'b0;
    endcase
    we = ok && dst != 5'd0;
    if (p_we) m_rf[p_dst] = p_val;
    p_we = we; p_dst = dst; p_val = d;
    e.a = a; e.b = b; e.d = d; e.age = 0;
    q.push_back(e);
    ibus = ins;
    @(posedge clk); #1;
    for (int i = 0; i < q.size(); i++) begin
      q[i].age = q[i].age + 1;
      if (q[i].age == 2) begin
        chk("abus", abus, q[i].a);
        chk("bbus", bbus, q[i].b);
      end
      if (q[i].age == 3) chk("dbus", dbus, q[i].d);
    end
    while (q.size() > 0 && q[0].age >= 3) void'(q.pop_front());
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_abus", abus, 32'd0);
    chk("rst_bbus", bbus, 32'd0);
    chk("rst_dbus", dbus, 32'd0);
    model_reset();
    ibus = 32'hDEAD_BEEF;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_hold_dbus", dbus, 32'd0);
    #2 rst_n = 1'b1;
  endtask
  initial begin
    logic [31:0] pool [12];
    model_reset();
    do_reset();
    issue(rt_(2, 0, 0, 13));
    issue(it_(3, 0, 1, 16'h0000));
    issue(it_(3, 0, 0, 16'hFFFF));
    issue(rt_(4, 0, 0, 9));
    issue(it_(12, 1, 21, 16'hF98B));
    issue(32'd0);
    issue(it_(2, 21, 31, 16'h0030));
    issue(it_(12, 0, 3, 16'h7334));
    issue(32'd0);
    issue(rt_(1, 1, 3, 16));
    issue(32'd0);
    issue(rt_(3, 16, 3, 24));
    issue(it_(3, 0, 13, 16'hFFFF));
    issue(it_(12, 0, 19, 16'h7334));
    issue(32'd0);
    issue(rt_(1, 13, 19, 2));
    issue(32'd0);
    issue(rt_(3, 2, 19, 14));
    issue(it_(1, 13, 27, 16'h0B31));
    issue(it_(3, 1, 5, 16'h0001));
    issue(rt_(3, 5, 5, 6));
    issue(it_(15, 13, 7, 16'h00F0));
    issue(rt_(7, 13, 19, 8));
    issue(rt_(4, 2, 3, 10));
    issue(rt_(6'h3F, 13, 19, 11));
    issue(it_(6'h3F, 13, 12, 16'h1234));
    issue(rt_(3, 11, 12, 4));
    pool[0] = 32'd0;
    for (int i = 0; i < 80; i++) begin
      int k = $urandom_range(0, 11);
      int s = $urandom_range(0, 7), t = $urandom_range(0, 7), d = $urandom_range(0, 7);
      logic [15:0] imm = 16'($urandom);
      case (k)
        0: issue(rt_(3, s, t, d));
        1: issue(rt_(2, s, t, d));
        2: issue(rt_(1, s, t, d));
        3: issue(rt_(7, s, t, d));
        4: issue(rt_(4, s, t, d));
        5: issue(it_(3, s, t, imm));
        6: issue(it_(2, s, t, imm));
        7: issue(it_(1, s, t, imm));
        8: issue(it_(15, s, t, imm));
        9: issue(it_(12, s, t, imm));
        10: issue(rt_(6'h3F, s, t, d));
        default: issue(it_(6'h3E, s, t, imm));
      endcase
    end
    issue(it_(12, 0, 3, 16'h5555));
    issue(rt_(3, 3, 3, 7));
    #2 do_reset();
    issue(rt_(4, 3, 0, 0));
    issue(rt_(4, 7, 0, 0));
    issue(rt_(3, 13, 19, 0));
    issue(it_(3, 0, 4, 16'h0002));
    issue(32'd0);
    issue(rt_(3, 4, 4, 5));
    for (int i = 0; i < 3; i++) issue(32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
